dprob_feeder: RTL
=================

# dprob_feeder

Stream source for the detection-probability stage of the YOLO bounding-box path. On a start pulse it walks every grid cell and anchor set, reads the packed per-box probability record from the box-score buffer, and emits one tagged element per cycle: prob_max, prob_min, prob_sum, scale, addr, set, valid, last. This is the stream the argmax stage consumes. After the final element it holds off for a flush window, so downstream max tracking can resolve and re-arm before the next frame starts.

## Interface

Parameters:
- NUM_CELLS, 169: grid cells per frame (13x13); range 1..256.
- NUM_SETS, 5: anchor sets per cell; range 1..8.
- RD_LATENCY, 2: buffer read latency in cycles; range 1..4.
- FLUSH_CYCLES, 24: idle cycles enforced after last element; minimum 1.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle frame start; honoured only in IDLE.
- busy, output, 1: high from the cycle after an accepted start until return to IDLE.
- done, output, 1: one-cycle pulse at end of flush window.
- rd_en, output, 1: buffer read strobe.
- rd_addr, output, 11: read address {set[2:0], addr[7:0]}.
- rd_data, input, 64: record {scale, prob_sum, prob_min, prob_max}, 16 bits each (fp16); valid RD_LATENCY cycles after rd_en.
- prob_max_out, output, 16: rd_data[15:0].
- prob_min_out, output, 16: rd_data[31:16].
- prob_sum_out, output, 16: rd_data[47:32].
- scale_out, output, 16: rd_data[63:48].
- valid_out, output, 1: element valid.
- last_out, output, 1: final element of frame; coincides with valid_out.
- addr_out, output, 8: cell index of element.
- set_out, output, 3: anchor set of element.
- pause_in, input, 1: present only with DPROB_FEED_PAUSE_EN.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE -> ISSUE on start. start received in any other state is ignored and does not queue.
- ISSUE:
  - rd_en=1 every cycle, with {set_cnt, addr_cnt} on rd_addr.
  - set_cnt is the inner loop (0..NUM_SETS-1). addr_cnt increments when set_cnt wraps to 0.
  - When the last read is issued (addr_cnt=NUM_CELLS-1, set_cnt=NUM_SETS-1), go to DRAIN. Both counters clear.
- Tag pipeline:
  - A shift pipeline of depth RD_LATENCY carries {last, valid, set, addr} alongside each read.
  - The last tag is set only on the final read.
- Output register:
  - When a tag emerges valid, rd_data and the tag are captured into the output registers.
  - valid_out is low in every other cycle. Data outputs hold their previous value when valid_out is low.
- DRAIN: wait until the tag pipeline has emitted last, then go to FLUSH. Load the flush counter with FLUSH_CYCLES-1.
- FLUSH:
  - Counts down to 0; at 0 assert done and go to IDLE.
  - busy is low in the cycle following done.
- Element count per frame is exactly NUM_CELLS*NUM_SETS. No duplicates. Order is (addr0,set0), (addr0,set1), ...
- Reset (reset_n low, any time including mid-frame):
  - State goes to IDLE; counters, tag pipeline and flush counter clear.
  - All outputs go to 0: busy, done, rd_en, rd_addr, the four prob/scale outputs, valid_out, last_out, addr_out, set_out.
  - In-flight rd_data after reset release is discarded, because the tags are cleared.

## Timing

- Start sampled high in cycle T while in IDLE:
  - busy and rd_en are first high in cycle T+1.
  - Read k (k=0..N-1, N=NUM_CELLS*NUM_SETS) is issued in cycle T+1+k.
  - valid_out for element k is high in cycle T+2+RD_LATENCY+k.
- Throughput: one element per cycle; no gaps without pause.
- last_out is high in cycle L=T+1+RD_LATENCY+N.
- done is high in cycle L+FLUSH_CYCLES; busy is low from L+FLUSH_CYCLES+1.
- Earliest next accepted start: cycle L+FLUSH_CYCLES+1.
- N=1 case: ISSUE lasts one cycle; the element carries valid_out and last_out together.

## Configuration

- DPROB_FEED_PAUSE_EN defined:
  - The pause_in port exists.
  - In ISSUE, pause_in=1 forces rd_en=0, holds both counters, and inserts an invalid tag.
  - Reads already in flight still emerge; valid_out shows matching gaps.
  - pause_in has no effect in IDLE, DRAIN or FLUSH.
- Not defined: the port is absent and ISSUE never stalls. Timing is exactly as above.

## Test plan

- NUM_CELLS=4, NUM_SETS=2, RD_LATENCY=2, start at cycle 10 -> rd_en high cycles 11..18. valid_out high cycles 14..21 with (addr,set) sequence (0,0),(0,1),(1,0)...(3,1). last_out only at cycle 21 with addr_out=3, set_out=1. done at 21+FLUSH_CYCLES.
- Buffer model returns record = {16'h3C00, 16'h4000+a, 16'h2000+a, 16'h1000+a} for read address a -> each output field matches its own address tag, checked per element.
- start pulsed again at cycle 15 and during FLUSH -> ignored: exactly 8 elements, one done, no second frame.
- reset_n low at cycle 16 mid-frame -> all outputs 0 immediately. After release, no valid_out until a new start; the new frame produces 8 elements.
- DPROB_FEED_PAUSE_EN with pause_in high cycles 12..13 -> 8 elements still delivered in order, valid_out gap of 2 cycles, last_out at cycle 23.
- NUM_CELLS=1, NUM_SETS=1, RD_LATENCY=1 -> single element with valid_out=last_out=1 at T+3. done at T+3+FLUSH_CYCLES.

Source files
------------

// File: rtl/dprob_feeder.sv
// dprob_feeder: walks every grid cell and anchor set, reads box-score records and
// streams tagged elements to the argmax stage. Optional stall input: DPROB_FEED_PAUSE_EN.
module dprob_feeder #(
  parameter int NUM_CELLS    = 169,
  parameter int NUM_SETS     = 5,
  parameter int RD_LATENCY   = 2,
  parameter int FLUSH_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef DPROB_FEED_PAUSE_EN
  input  logic        pause_in,
`endif
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [10:0] rd_addr,
  input  logic [63:0] rd_data,
  output logic [15:0] prob_max_out,
  output logic [15:0] prob_min_out,
  output logic [15:0] prob_sum_out,
  output logic [15:0] scale_out,
  output logic        valid_out,
  output logic        last_out,
  output logic [7:0]  addr_out,
  output logic [2:0]  set_out
);

  localparam int              FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [7:0]      ADDR_MAX   = 8'(NUM_CELLS - 1);
  localparam logic [2:0]      SET_MAX    = 3'(NUM_SETS - 1);
  localparam logic [FW-1:0]   FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [2:0]      set_cnt_q, set_cnt_d;
  logic [7:0]      addr_cnt_q, addr_cnt_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic            issue;
  logic            final_rd;
  logic            stall;

  // Tag layout: {last, valid, set[2:0], addr[7:0]}
  logic [12:0]     tag_d;
  logic [12:0]     tag_q [RD_LATENCY];
  logic [12:0]     tag_out;

  logic [63:0]     data_q;
  logic            valid_q;
  logic            last_q;
  logic [7:0]      aout_q;
  logic [2:0]      sout_q;

`ifdef DPROB_FEED_PAUSE_EN
  assign stall = pause_in;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    addr_cnt_d = addr_cnt_q;
    flush_d    = flush_q;
    issue      = 1'b0;
    final_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        if (!stall) begin
          issue = 1'b1;
          if (set_cnt_q == SET_MAX) begin
            set_cnt_d = '0;
            if (addr_cnt_q == ADDR_MAX) begin
              final_rd   = 1'b1;
              addr_cnt_d = '0;
              state_d    = DRAIN;
            end else begin
              addr_cnt_d = addr_cnt_q + 8'd1;
            end
          end else begin
            set_cnt_d = set_cnt_q + 3'd1;
          end
        end
      end
      DRAIN: begin
        // Leave only once the final element has actually been presented downstream.
        if (valid_q && last_q) begin
          state_d = FLUSH;
          flush_d = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_d = IDLE;
        else               flush_d = flush_q - FW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      set_cnt_q  <= '0;
      addr_cnt_q <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      flush_q    <= flush_d;
    end
  end

  assign tag_d   = {final_rd, issue, set_cnt_q, addr_cnt_q};
  assign tag_out = tag_q[RD_LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Data fields only update on valid tags so they hold across gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      aout_q  <= '0;
      sout_q  <= '0;
    end else begin
      valid_q <= tag_out[11];
      last_q  <= tag_out[11] & tag_out[12];
      if (tag_out[11]) begin
        data_q <= rd_data;
        sout_q <= tag_out[10:8];
        aout_q <= tag_out[7:0];
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FLUSH) && (flush_q == '0);
  assign rd_en        = issue;
  assign rd_addr      = {set_cnt_q, addr_cnt_q};
  assign prob_max_out = data_q[15:0];
  assign prob_min_out = data_q[31:16];
  assign prob_sum_out = data_q[47:32];
  assign scale_out    = data_q[63:48];
  assign valid_out    = valid_q;
  assign last_out     = last_q;
  assign addr_out     = aout_q;
  assign set_out      = sout_q;

endmodule
